// File: rtl/gnn_seq_ctrl_if.sv
// Handshake and control bundle between the GNN frame sequencer and the datapath / shared layer engine.
// master = sequencer side, slave = datapath/engine side.
interface gnn_seq_ctrl_if;
  logic       in_valid;
  logic       in_ready;
  logic       agg_in_en;
  logic       eng_start;
  logic       eng_mode;
  logic [1:0] eng_node;
  logic       eng_done;
  logic       hid_wr_en;
  logic       agg_out_en;
  logic [3:0] out_valid;
  logic       busy;
  logic       err;
  logic [7:0] frame_cnt;

  modport master (
    input  in_valid, eng_done,
    output in_ready, agg_in_en, eng_start, eng_mode, eng_node, hid_wr_en,
           agg_out_en, out_valid, busy, err, frame_cnt
  );

  modport slave (
    output in_valid, eng_done,
    input  in_ready, agg_in_en, eng_start, eng_mode, eng_node, hid_wr_en,
           agg_out_en, out_valid, busy, err, frame_cnt
  );
endinterface

// File: rtl/gnn_seq_ctrl.sv
// Frame sequencer for the 4-node, 2-layer GNN datapath: AGG1 -> hidden layer x4 -> AGG2 -> output layer x4.
// Optional engine watchdog compiled in with `define GNN_SEQ_WDOG_EN (engine latency must be >= 1 cycle).
module gnn_seq_ctrl #(
  parameter int NUM_NODES = 4
`ifdef GNN_SEQ_WDOG_EN
  ,
  parameter int WDOG_CYCLES = 255
`endif
) (
  input  logic           clk,
  input  logic           rst,
  gnn_seq_ctrl_if.master bus
);

  localparam logic [1:0] NODE_LAST = 2'(NUM_NODES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_AGG1,
    S_HID_ISSUE,
    S_HID_WAIT,
    S_AGG2,
    S_OUT_ISSUE,
    S_OUT_WAIT
  } state_t;

  state_t               state_reg, state_next;
  logic [1:0]           node_reg, node_next;
  logic [7:0]           frame_cnt_reg, frame_cnt_next;
  logic [NUM_NODES-1:0] out_valid_reg;

  logic frame_accept;
  logic hid_land;
  logic out_land;
  logic wait_stall;

  logic agg_in_en_reg;
  logic eng_start_reg;
  logic eng_mode_reg;
  logic agg_out_en_reg;
  logic in_ready_reg;
  logic busy_reg;

`ifdef GNN_SEQ_WDOG_EN
  logic [7:0] wdog_cnt_reg, wdog_cnt_next;
  logic       wdog_abort;
  logic       err_reg;
`endif

  // A WAIT cycle without a completion is what the watchdog counts.
  assign wait_stall = ((state_reg == S_HID_WAIT) || (state_reg == S_OUT_WAIT)) && !bus.eng_done;

  always_comb begin
    state_next     = state_reg;
    node_next      = node_reg;
    frame_cnt_next = frame_cnt_reg;
    frame_accept   = 1'b0;
    hid_land       = 1'b0;
    out_land       = 1'b0;
    case (state_reg)
      S_IDLE: begin
        if (bus.in_valid) begin
          frame_accept = 1'b1;
          node_next    = 2'd0;
          state_next   = S_AGG1;
        end
      end
      S_AGG1:      state_next = S_HID_ISSUE;
      S_HID_ISSUE: state_next = S_HID_WAIT;
      S_HID_WAIT: begin
        if (bus.eng_done) begin
          hid_land = 1'b1;
          if (node_reg == NODE_LAST) begin
            state_next = S_AGG2;
          end else begin
            node_next  = node_reg + 2'd1;
            state_next = S_HID_ISSUE;
          end
        end
`ifdef GNN_SEQ_WDOG_EN
        else if (wdog_abort) begin
          state_next = S_IDLE;
        end
`endif
      end
      S_AGG2: begin
        node_next  = 2'd0;
        state_next = S_OUT_ISSUE;
      end
      S_OUT_ISSUE: state_next = S_OUT_WAIT;
      S_OUT_WAIT: begin
        if (bus.eng_done) begin
          out_land = 1'b1;
          if (node_reg == NODE_LAST) begin
            frame_cnt_next = frame_cnt_reg + 8'd1;
            state_next     = S_IDLE;
          end else begin
            node_next  = node_reg + 2'd1;
            state_next = S_OUT_ISSUE;
          end
        end
`ifdef GNN_SEQ_WDOG_EN
        else if (wdog_abort) begin
          state_next = S_IDLE;
        end
`endif
      end
      default: state_next = S_IDLE;
    endcase
  end

`ifdef GNN_SEQ_WDOG_EN
  // Counter is zero on the first WAIT cycle; abort fires as the count reaches the limit.
  always_comb begin
    wdog_cnt_next = wdog_cnt_reg;
    wdog_abort    = 1'b0;
    if ((state_reg == S_HID_ISSUE) || (state_reg == S_OUT_ISSUE)) begin
      wdog_cnt_next = 8'd0;
    end else if (wait_stall) begin
      wdog_cnt_next = wdog_cnt_reg + 8'd1;
      wdog_abort    = (wdog_cnt_next == 8'(WDOG_CYCLES));
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wdog_cnt_reg <= 8'd0;
      err_reg      <= 1'b0;
    end else begin
      wdog_cnt_reg <= wdog_cnt_next;
      if (frame_accept) begin
        err_reg <= 1'b0;
      end else if (wdog_abort) begin
        err_reg <= 1'b1;
      end
    end
  end

  assign bus.err = err_reg;
`else
  assign bus.err = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= S_IDLE;
      node_reg      <= 2'd0;
      frame_cnt_reg <= 8'd0;
    end else begin
      state_reg     <= state_next;
      node_reg      <= node_next;
      frame_cnt_reg <= frame_cnt_next;
    end
  end

  // Strobes are decoded from the next state and registered so they are glitch-free and mutually exclusive.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      agg_in_en_reg  <= 1'b0;
      eng_start_reg  <= 1'b0;
      eng_mode_reg   <= 1'b0;
      agg_out_en_reg <= 1'b0;
      in_ready_reg   <= 1'b1;
      busy_reg       <= 1'b0;
    end else begin
      agg_in_en_reg  <= (state_next == S_AGG1);
      eng_start_reg  <= (state_next == S_HID_ISSUE) || (state_next == S_OUT_ISSUE);
      eng_mode_reg   <= (state_next == S_OUT_ISSUE) || (state_next == S_OUT_WAIT);
      agg_out_en_reg <= (state_next == S_AGG2);
      in_ready_reg   <= (state_next == S_IDLE);
      busy_reg       <= (state_next != S_IDLE);
    end
  end

  // Per-node sticky result flags: cleared only by a new frame (or reset), kept across a watchdog abort.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_NODES; gi++) begin : g_node_flag
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          out_valid_reg[gi] <= 1'b0;
        end else if (frame_accept) begin
          out_valid_reg[gi] <= 1'b0;
        end else if (out_land && (node_reg == 2'(gi))) begin
          out_valid_reg[gi] <= 1'b1;
        end
      end
    end
  endgenerate

  assign bus.in_ready   = in_ready_reg;
  assign bus.agg_in_en  = agg_in_en_reg;
  assign bus.eng_start  = eng_start_reg;
  assign bus.eng_mode   = eng_mode_reg;
  assign bus.eng_node   = node_reg;
  assign bus.hid_wr_en  = hid_land;
  assign bus.agg_out_en = agg_out_en_reg;
  assign bus.out_valid  = out_valid_reg;
  assign bus.busy       = busy_reg;
  assign bus.frame_cnt  = frame_cnt_reg;

endmodule

// File: tb/tb_gnn_seq_ctrl.sv
// Bench for gnn_seq_ctrl: latency-L engine responder, per-cycle timeline model, directed frame scenarios.
module tb_gnn_seq_ctrl;
  logic clk = 1'b0;
  logic rst;

  gnn_seq_ctrl_if bus ();

  gnn_seq_ctrl dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d actual=%0d required=%0d", name, cyc, act, exp);
    end
  endtask

  // Engine responder: eng_done exactly eng_lat cycles after each eng_start, plus injected spurious pulses.
  int eng_lat   = 1;
  bit hang_hid1 = 1'b0;
  bit done_sched[int];
  bit spur_sched[int];

  initial begin
    bus.eng_done = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      bus.eng_done = done_sched.exists(cyc) || spur_sched.exists(cyc);
    end
  end

  // Frame model: every output is a function of the cycle offset t from the AGG1 cycle.
  bit         m_active = 1'b0;
  bit         m_off    = 1'b0;
  int         m_t0     = 0;
  int         m_L      = 1;
  logic [3:0] m_ov     = 4'd0;
  logic [7:0] m_fc     = 8'd0;
  logic       m_err    = 1'b0;
  int         start_log[$];

  always @(negedge clk) begin
    int         t;
    logic       e_agg_in, e_start, e_hwr, e_agg_out, e_mode;
    logic [1:0] e_node;
    logic [3:0] e_ov;
    if (!rst && bus.eng_start === 1'b1)
      if (!(hang_hid1 && bus.eng_mode == 1'b0 && bus.eng_node == 2'd1))
        done_sched[cyc + eng_lat] = 1'b1;
    if (rst) begin
      m_active = 1'b0;
      m_ov     = 4'd0;
      m_fc     = 8'd0;
      m_err    = 1'b0;
      chk("rst_in_ready", bus.in_ready, 1);
      chk("rst_busy", bus.busy, 0);
      chk("rst_strobes", {bus.agg_in_en, bus.eng_start, bus.agg_out_en, bus.eng_mode}, 0);
      chk("rst_out_valid", bus.out_valid, 0);
      chk("rst_frame_cnt", bus.frame_cnt, 0);
      chk("rst_err", bus.err, 0);
    end else if (!m_off) begin
      t = 0;
      e_agg_in = 0; e_start = 0; e_hwr = 0; e_agg_out = 0; e_mode = 0; e_node = 0;
      e_ov = m_ov;
      if (m_active) begin
        t         = cyc - m_t0;
        e_agg_in  = (t == 0);
        e_agg_out = (t == 4 * m_L + 5);
        for (int n = 0; n < 4; n++) begin
          if (t == 1 + n * (m_L + 1)) begin e_start = 1; e_mode = 0; e_node = 2'(n); end
          if (t == 1 + n * (m_L + 1) + m_L) e_hwr = 1;
          if (t == 2 + (4 + n) * (m_L + 1)) begin e_start = 1; e_mode = 1; e_node = 2'(n); end
          if (t >= 3 + (4 + n) * (m_L + 1) + m_L) e_ov[n] = 1'b1;
        end
        if (bus.eng_start === 1'b1) start_log.push_back(t);
      end
      chk("in_ready", bus.in_ready, !m_active);
      chk("busy", bus.busy, m_active);
      chk("agg_in_en", bus.agg_in_en, e_agg_in);
      chk("eng_start", bus.eng_start, e_start);
      chk("agg_out_en", bus.agg_out_en, e_agg_out);
      chk("hid_wr_en", bus.hid_wr_en, e_hwr);
      chk("out_valid", bus.out_valid, e_ov);
      chk("frame_cnt", bus.frame_cnt, m_fc);
      chk("err", bus.err, m_err);
      if (e_start) begin
        chk("eng_mode", bus.eng_mode, e_mode);
        chk("eng_node", bus.eng_node, e_node);
      end
      if (m_active && t == 8 * m_L + 9) begin
        m_active = 1'b0;
        m_ov     = 4'hF;
        m_fc     = m_fc + 8'd1;
      end else if (!m_active && bus.in_valid) begin
        m_active = 1'b1;
        m_t0     = cyc + 1;
        m_L      = eng_lat;
        m_ov     = 4'd0;
        m_err    = 1'b0;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic at_neg(input int c);
    forever begin
      @(negedge clk);
      if (cyc >= c) break;
    end
  endtask

  task automatic do_reset();
    tick();
    rst = 1'b1;
    done_sched.delete();
    tick();
    tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic run_frame();
    int n;
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    n = 0;
    while (!bus.in_ready && n < 200) begin
      tick();
      n++;
    end
    chk("frame_complete_in_budget", (n < 200), 1);
  endtask

  int t0;
  int k;
  int exp_starts[8] = '{1, 3, 5, 7, 10, 12, 14, 16};

  initial begin
    rst          = 1'b1;
    bus.in_valid = 1'b0;
    tick();
    tick();
    @(negedge clk);
    chk("lit_reset_in_ready", bus.in_ready, 1);
    chk("lit_reset_busy", bus.busy, 0);
    tick();
    rst = 1'b0;
    tick();
    tick();

    // L = 1 single frame with literal timeline.
    eng_lat = 1;
    start_log.delete();
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    t0 = cyc;
    for (int t = 0; t <= 18; t++) begin
      @(negedge clk);
      if (t == 0)  chk("lit_agg_in_c0", bus.agg_in_en, 1);
      if (t == 9)  chk("lit_agg_out_c9", bus.agg_out_en, 1);
      if (t == 17) chk("lit_out_valid_c17", bus.out_valid, 4'b0111);
      if (t == 18) begin
        chk("lit_out_valid_c18", bus.out_valid, 4'b1111);
        chk("lit_frame_cnt_c18", bus.frame_cnt, 1);
        chk("lit_in_ready_c18", bus.in_ready, 1);
      end
    end
    tick();
    chk("lit_start_count", start_log.size(), 8);
    for (int i = 0; i < 8 && i < start_log.size(); i++)
      chk($sformatf("lit_start_cycle_%0d", i), start_log[i], exp_starts[i]);

    // L = 3 with in_valid held: back-to-back acceptance on the first IDLE cycle.
    do_reset();
    eng_lat = 3;
    bus.in_valid = 1'b1;
    t0 = cyc + 1;
    at_neg(t0 + 34);
    chk("lit_b2b_in_ready_c34", bus.in_ready, 1);
    chk("lit_b2b_out_valid_c34", bus.out_valid, 4'hF);
    chk("lit_b2b_frame_cnt_c34", bus.frame_cnt, 1);
    at_neg(t0 + 35);
    chk("lit_b2b_agg_in_c35", bus.agg_in_en, 1);
    chk("lit_b2b_out_valid_cleared", bus.out_valid, 0);
    tick();
    bus.in_valid = 1'b0;
    at_neg(t0 + 69);
    chk("lit_b2b_frame_cnt_2", bus.frame_cnt, 2);
    tick();

    // Spurious eng_done in IDLE, AGG1 and HID_ISSUE.
    eng_lat = 1;
    k = cyc;
    spur_sched[k + 1] = 1'b1;
    spur_sched[k + 2] = 1'b1;
    spur_sched[k + 3] = 1'b1;
    spur_sched[k + 4] = 1'b1;
    spur_sched[k + 6] = 1'b1;
    tick();
    tick();
    bus.in_valid = 1'b1;
    t0 = cyc + 1;
    tick();
    bus.in_valid = 1'b0;
    at_neg(t0);
    chk("lit_spur_agg1_hwr", bus.hid_wr_en, 0);
    at_neg(t0 + 1);
    chk("lit_spur_issue_hwr", bus.hid_wr_en, 0);
    chk("lit_spur_issue_start", bus.eng_start, 1);
    at_neg(t0 + 2);
    chk("lit_spur_wait_hwr", bus.hid_wr_en, 1);
    at_neg(t0 + 3);
    chk("lit_spur_node1_start", bus.eng_node, 1);
    at_neg(t0 + 18);
    chk("lit_spur_frame_cnt", bus.frame_cnt, 3);
    tick();

    // Reset during OUT_WAIT for node 2.
    bus.in_valid = 1'b1;
    t0 = cyc + 1;
    tick();
    bus.in_valid = 1'b0;
    at_neg(t0 + 14);
    chk("lit_pre_rst_out_valid", bus.out_valid, 4'b0011);
    chk("lit_pre_rst_node", bus.eng_node, 2);
    tick();
    rst = 1'b1;
    done_sched.delete();
    @(negedge clk);
    chk("lit_midrst_out_valid", bus.out_valid, 0);
    chk("lit_midrst_frame_cnt", bus.frame_cnt, 0);
    chk("lit_midrst_in_ready", bus.in_ready, 1);
    tick();
    rst = 1'b0;
    tick();
    run_frame();
    chk("lit_post_rst_frame_cnt", bus.frame_cnt, 1);
    chk("lit_post_rst_out_valid", bus.out_valid, 4'hF);

    // 256 frames: frame_cnt wraps.
    do_reset();
    for (int i = 1; i <= 256; i++) begin
      run_frame();
      if (i == 255) chk("lit_wrap_255", bus.frame_cnt, 255);
      if (i == 256) chk("lit_wrap_0", bus.frame_cnt, 0);
    end

`ifdef GNN_SEQ_WDOG_EN
    // Engine never answers hidden node 1.
    tick();
    m_off     = 1'b1;
    hang_hid1 = 1'b1;
    bus.in_valid = 1'b1;
    t0 = cyc + 1;
    tick();
    bus.in_valid = 1'b0;
    k = t0 + 3;
    at_neg(k);
    chk("lit_wdog_start_node1", bus.eng_node, 1);
    at_neg(k + 255);
    chk("lit_wdog_still_busy", bus.busy, 1);
    chk("lit_wdog_no_err_yet", bus.err, 0);
    at_neg(k + 256);
    chk("lit_wdog_idle", bus.busy, 0);
    chk("lit_wdog_err", bus.err, 1);
    chk("lit_wdog_frame_cnt", bus.frame_cnt, m_fc);
    chk("lit_wdog_out_valid", bus.out_valid, 0);
    m_active  = 1'b0;
    m_ov      = 4'd0;
    m_err     = 1'b1;
    hang_hid1 = 1'b0;
    m_off     = 1'b0;
    tick();
    run_frame();
    chk("lit_wdog_err_cleared", bus.err, 0);
    chk("lit_wdog_next_frame_cnt", bus.frame_cnt, 1);
`endif

    tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    failures++;
    $display("FAIL global_timeout cyc=%0d actual=running required=finished", cyc);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
